aes_round_sched: RTL
====================

AES_ROUND_SCHED -- requirements
Module: aes_round_sched

Interface
REQ-001 Parameter: NR, 10, total cipher rounds (legal 10/12/14); last full round is NR-1, final round is NR.
REQ-002 Parameter: CNT_W, 16, width of completed-block counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 in_valid  input  1  new block (state+key) presented to datapath inputs.
REQ-006 in_ready  output  1  scheduler idle, can accept a block.
REQ-007 abort  input  1  synchronous cancel of current block.
REQ-008 rk_req  output  1  request round key rk_idx from key-expansion unit.
REQ-009 rk_idx  output  4  round-key index, 0..NR.
REQ-010 rk_valid  input  1  requested round key available this cycle.
REQ-011 dp_load  output  1  one-cycle strobe: datapath captures input block.
REQ-012 dp_en  output  1  one-cycle strobe: datapath applies operation dp_mode with key rk_idx.
REQ-013 dp_mode  output  2  0 IDLE, 1 INIT (add-key only), 2 FULL (sub/shift/mix/add), 3 FINAL (sub/shift/add).
REQ-014 out_valid  output  1  datapath holds finished ciphertext.
REQ-015 out_ready  input  1  consumer accepts ciphertext.
REQ-016 blk_cnt  output  CNT_W  count of blocks completed (out_valid&out_ready).

Function
REQ-017 FSM states: IDLE, KEYREQ, DONE.
REQ-018 IDLE: in_ready=1; on in_valid&in_ready -> dp_load=1 same cycle, rk_idx<=0, next KEYREQ.
REQ-019 KEYREQ: rk_req=1, rk_idx stable until rk_valid sampled 1; rk_valid may be 1 in the first KEYREQ cycle (zero wait).
REQ-020 KEYREQ with rk_valid=1: dp_en=1 that cycle, dp_mode = INIT if rk_idx=0, FULL if 1..NR-1, FINAL if rk_idx=NR.
REQ-021 KEYREQ with rk_valid=1 and rk_idx<NR: rk_idx<=rk_idx+1, stay KEYREQ; rk_idx=NR: next DONE, rk_idx<=0.
REQ-022 dp_en=0 and dp_mode=IDLE whenever rk_valid=0 or state is not KEYREQ.
REQ-023 DONE: out_valid=1, held until out_ready=1; on that cycle blk_cnt<=blk_cnt+1 (wraps 2^CNT_W-1 -> 0), next IDLE.
REQ-024 in_ready=0 in KEYREQ and DONE; in_valid there is ignored; one idle cycle between blocks.
REQ-025 Latency with rk_valid tied 1: accept at cycle T, dp_en at T+1..T+NR+1, out_valid from T+NR+2.
REQ-026 abort=1 in any state: next state IDLE, rk_idx<=0; same cycle dp_en=0, rk_req=0, out_valid=0, dp_load=0; abort beats rk_valid, in_valid, out_ready; blk_cnt unchanged.
REQ-027 abort in IDLE with in_valid=1: block not accepted.
REQ-028 rk_req, dp_en, dp_load, out_valid are decoded from state and inputs without extra pipeline delay; in_ready is registered.

Reset
REQ-029 While rst=0: state IDLE, rk_idx=0, blk_cnt=0, in_ready=0, rk_req=0, dp_load=0, dp_en=0, dp_mode=0, out_valid=0.
REQ-030 in_ready rises on the first rising clk edge after rst returns to 1.
REQ-031 Reset asserted mid-block discards the block with no dp_en or out_valid afterwards.

Structure
REQ-032 Shared package aes_pkg holds dp_mode encodings (DP_IDLE, DP_INIT, DP_FULL, DP_FINAL), FSM state enum and default NR.
REQ-033 Single module, no sub-modules; one FSM plus rk_idx and blk_cnt counters.

Verification
REQ-034 NR=10, rk_valid=1, out_ready=1, accept at T -> dp_load at T, dp_en at T+1..T+11 with modes INIT, FULL x9, FINAL, rk_idx 0..10, out_valid at T+12, blk_cnt=1.
REQ-035 rk_valid low 3 cycles per key -> rk_idx held stable while rk_req=1, exactly 11 dp_en pulses, out_valid at T+45.
REQ-036 out_ready=0 for 5 cycles in DONE -> out_valid held 6 cycles, in_ready=0 throughout, blk_cnt increments once.
REQ-037 abort at rk_idx=4 with rk_valid=1 -> no dp_en that cycle, IDLE next cycle, new block restarts at rk_idx=0.
REQ-038 Preload blk_cnt to 0xFFFF, complete one block -> blk_cnt=0x0000.
REQ-039 rst=0 asserted at rk_idx=7 -> all outputs 0 at once; after release, in_ready=1 next edge, no out_valid.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES round scheduler.
//   dp_mode_e : operation the datapath applies when dp_en strobes
//   state_e   : scheduler FSM states
//   NR_DEFAULT: default number of cipher rounds (AES-128)
package aes_pkg;

  typedef enum logic [1:0] {
    DP_IDLE  = 2'd0,  // no operation
    DP_INIT  = 2'd1,  // initial AddRoundKey only
    DP_FULL  = 2'd2,  // SubBytes, ShiftRows, MixColumns, AddRoundKey
    DP_FINAL = 2'd3   // SubBytes, ShiftRows, AddRoundKey (no MixColumns)
  } dp_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_KEYREQ = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int NR_DEFAULT = 10;

endpackage

// File: rtl/aes_round_sched.sv
// AES round scheduler: sequences one block through the initial key add,
// NR-1 full rounds and the final round, fetching one round key per step
// from an external key-expansion unit.
//
// Parameters
//   NR    : total cipher rounds (10, 12 or 14)
//   CNT_W : width of the completed-block counter
// Ports
//   clk       : clock, all state updates on rising edge
//   rst       : asynchronous reset, active low
//   in_valid  : new block presented to the datapath inputs
//   in_ready  : registered, scheduler idle and able to accept a block
//   abort     : synchronous cancel of the current block
//   rk_req    : request round key rk_idx
//   rk_idx    : round-key index 0..NR
//   rk_valid  : requested round key available this cycle
//   dp_load   : datapath captures the input block
//   dp_en     : datapath applies dp_mode with key rk_idx
//   dp_mode   : IDLE / INIT / FULL / FINAL
//   out_valid : datapath holds finished ciphertext
//   out_ready : consumer accepts ciphertext
//   blk_cnt   : number of completed blocks (wraps)
module aes_round_sched
  import aes_pkg::*;
#(
  parameter int NR    = NR_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             rk_req,
  output logic [3:0]       rk_idx,
  input  logic             rk_valid,
  output logic             dp_load,
  output logic             dp_en,
  output logic [1:0]       dp_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_e state_q;
  state_e state_d;
  logic   last_key;
  logic   accept;
  logic   key_take;
  logic   done_hs;

  assign last_key = (rk_idx == LAST_IDX);

  // Strobes are decoded straight from the current state and inputs so the
  // datapath sees them in the same cycle; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    rk_req    = 1'b0;
    dp_load   = 1'b0;
    dp_en     = 1'b0;
    dp_mode   = DP_IDLE;
    out_valid = 1'b0;
    accept    = 1'b0;
    key_take  = 1'b0;
    done_hs   = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            accept  = 1'b1;
            dp_load = 1'b1;
            state_d = ST_KEYREQ;
          end
        end
        ST_KEYREQ: begin
          rk_req = 1'b1;
          if (rk_valid) begin
            key_take = 1'b1;
            dp_en    = 1'b1;
            if (rk_idx == 4'd0) begin
              dp_mode = DP_INIT;
            end else if (last_key) begin
              dp_mode = DP_FINAL;
            end else begin
              dp_mode = DP_FULL;
            end
            if (last_key) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          out_valid = 1'b1;
          if (out_ready) begin
            done_hs = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // in_ready is registered from the next state, so it only rises on the
  // first clock edge after reset release and is low for the whole block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      in_ready <= 1'b0;
      rk_idx   <= 4'd0;
      blk_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d == ST_IDLE);
      if (abort || accept) begin
        rk_idx <= 4'd0;
      end else if (key_take) begin
        rk_idx <= last_key ? 4'd0 : rk_idx + 4'd1;
      end
      if (done_hs) begin
        blk_cnt <= blk_cnt + CNT_W'(1);
      end
    end
  end

endmodule
